// File: rtl/fft_pkg.sv
// Shared definitions for the FFT input framer: default sample geometry and
// the issue-FSM state encoding.
package fft_pkg;

  localparam int FFT_SAMPLE_W  = 8;
  localparam int FFT_FRAME_LEN = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } issue_state_e;

endpackage

// File: rtl/fft_frame_bank.sv
// One frame bank: four sample registers written one slot at a time.
module fft_frame_bank #(
  parameter int SAMPLE_W = fft_pkg::FFT_SAMPLE_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [1:0]          widx,
  input  logic [SAMPLE_W-1:0] wdata,
  output logic [SAMPLE_W-1:0] d0,
  output logic [SAMPLE_W-1:0] d1,
  output logic [SAMPLE_W-1:0] d2,
  output logic [SAMPLE_W-1:0] d3
);

  logic [SAMPLE_W-1:0] mem_q [4];
  logic [SAMPLE_W-1:0] mem_d [4];

  // Next bank contents: only the addressed slot changes on a write.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[widx] = wdata;
    end
  end

  // Bank storage; cleared on reset so a discarded frame never leaks out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign d0 = mem_q[0];
  assign d1 = mem_q[1];
  assign d2 = mem_q[2];
  assign d3 = mem_q[3];

endmodule

// File: rtl/fft_input_framer.sv
// Ping-pong framer: collects 4 samples per bank and issues each full bank
// to a 4-point FFT, holding it until the FFT reports completion.
module fft_input_framer
  import fft_pkg::*;
#(
  parameter int SAMPLE_W  = FFT_SAMPLE_W,
  parameter int FRAME_LEN = FFT_FRAME_LEN
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_data,
  output logic                in_ready,
  output logic                start,
  output logic [SAMPLE_W-1:0] x0,
  output logic [SAMPLE_W-1:0] x1,
  output logic [SAMPLE_W-1:0] x2,
  output logic [SAMPLE_W-1:0] x3,
  input  logic                fft_done,
  output logic                busy,
  output logic [7:0]          frame_cnt
);

  localparam logic [1:0] FILL_LAST = 2'(FRAME_LEN - 1);

  issue_state_e state_q, state_d;
  logic         wb_q, wb_d;
  logic         rb_q, rb_d;
  logic [1:0]   full_q, full_d;
  logic [1:0]   fill_q, fill_d;
  logic [7:0]   frame_cnt_q, frame_cnt_d;
  logic         accept;
  logic         fill_done;
  logic         release_frame;

  logic [SAMPLE_W-1:0] a0, a1, a2, a3;
  logic [SAMPLE_W-1:0] b0, b1, b2, b3;

  assign in_ready  = ~full_q[wb_q];
  assign accept    = in_valid & in_ready;
  assign fill_done = accept && (fill_q == FILL_LAST);

  fft_frame_bank #(.SAMPLE_W(SAMPLE_W)) u_bank_a (
    .clk   (clk),
    .reset (reset),
    .we    (accept & ~wb_q),
    .widx  (fill_q),
    .wdata (in_data),
    .d0    (a0),
    .d1    (a1),
    .d2    (a2),
    .d3    (a3)
  );

  fft_frame_bank #(.SAMPLE_W(SAMPLE_W)) u_bank_b (
    .clk   (clk),
    .reset (reset),
    .we    (accept & wb_q),
    .widx  (fill_q),
    .wdata (in_data),
    .d0    (b0),
    .d1    (b1),
    .d2    (b2),
    .d3    (b3)
  );

  // Write side: advance the fill slot; on the last slot flip to the other bank.
  always_comb begin
    wb_d   = wb_q;
    fill_d = fill_q;
    if (accept) begin
      fill_d = fill_q + 2'd1;
      if (fill_done) begin
        fill_d = '0;
        wb_d   = ~wb_q;
      end
    end
  end

  // Issue FSM: launch a full read bank, then wait for the FFT to release it.
  always_comb begin
    state_d       = state_q;
    rb_d          = rb_q;
    frame_cnt_d   = frame_cnt_q;
    release_frame = 1'b0;
    case (state_q)
      ST_IDLE:  if (full_q[rb_q]) state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (fft_done) begin
          release_frame = 1'b1;
          rb_d          = ~rb_q;
          frame_cnt_d   = frame_cnt_q + 8'd1;
          state_d       = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Full flags: fill and release always target different banks, so both apply.
  always_comb begin
    full_d = full_q;
    if (fill_done)     full_d[wb_q] = 1'b1;
    if (release_frame) full_d[rb_q] = 1'b0;
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      full_q      <= '0;
      fill_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wb_q        <= wb_d;
      rb_q        <= rb_d;
      full_q      <= full_d;
      fill_q      <= fill_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Outputs: the read bank is presented only while a frame is issued.
  always_comb begin
    start     = (state_q == ST_START);
    busy      = (state_q != ST_IDLE);
    frame_cnt = frame_cnt_q;
    x0        = '0;
    x1        = '0;
    x2        = '0;
    x3        = '0;
    if (busy) begin
      x0 = rb_q ? b0 : a0;
      x1 = rb_q ? b1 : a1;
      x2 = rb_q ? b2 : a2;
      x3 = rb_q ? b3 : a3;
    end
  end

endmodule

// File: tb/tb_fft_input_framer.sv
// Directed bench for fft_input_framer.
module tb_fft_input_framer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       start;
  logic [7:0] x0, x1, x2, x3;
  logic       fft_done;
  logic       busy;
  logic [7:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q [$];
  int         frames_seen;
  int         resp;
  int         n;

  always #5 clk = ~clk;

  fft_input_framer #(.SAMPLE_W(8), .FRAME_LEN(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .start     (start),
    .x0        (x0),
    .x1        (x1),
    .x2        (x2),
    .x3        (x3),
    .fft_done  (fft_done),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input int e0, input int e1, input int e2, input int e3);
    check({tag, "_x0"}, 32'(x0), 32'(e0));
    check({tag, "_x1"}, 32'(x1), 32'(e1));
    check({tag, "_x2"}, 32'(x2), 32'(e2));
    check({tag, "_x3"}, 32'(x3), 32'(e3));
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    fft_done = 1'b0;
    step();
    step();
    check("rst_start", 32'(start), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(in_ready), 1);
    check("rst_cnt", 32'(frame_cnt), 0);
    check_frame("rst", 0, 0, 0, 0);
    reset = 1'b0;
    step();

    // fft_done while idle and empty is ignored
    fft_done = 1'b1;
    step();
    fft_done = 1'b0;
    check("idle_done_cnt", 32'(frame_cnt), 0);
    check("idle_done_busy", 32'(busy), 0);

    // single frame 10,20,30,40
    in_valid = 1'b1;
    in_data = 8'd10; step();
    in_data = 8'd20; step();
    in_data = 8'd30; step();
    in_data = 8'd40; step();
    in_valid = 1'b0;
    check("f1_no_start_yet", 32'(start), 0);
    check("f1_ready_other_bank", 32'(in_ready), 1);
    fft_done = 1'b1;             // held across the IDLE and START edges
    step();
    check("f1_start", 32'(start), 1);
    check("f1_busy", 32'(busy), 1);
    check_frame("f1", 10, 20, 30, 40);
    check("f1_cnt_idle_done", 32'(frame_cnt), 0);
    step();
    fft_done = 1'b0;
    check("f1_start_pulse", 32'(start), 0);
    check("f1_busy_wait", 32'(busy), 1);
    check("f1_cnt_start_done", 32'(frame_cnt), 0);
    check_frame("f1_hold", 10, 20, 30, 40);
    step();
    check("f1_still_wait", 32'(busy), 1);
    fft_done = 1'b1;
    step();
    fft_done = 1'b0;
    check("f1_cnt_rel", 32'(frame_cnt), 1);
    check("f1_busy_rel", 32'(busy), 0);
    check("f1_x0_idle", 32'(x0), 0);

    // 12 samples streamed with fft_done held low
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'(101 + i);
      check("s12_ready", 32'(in_ready), 1);
      step();
    end
    check("s12_ready_low", 32'(in_ready), 0);
    in_data = 8'd109;
    step();
    step();
    check("s12_ready_held", 32'(in_ready), 0);
    check("s12_busy", 32'(busy), 1);
    check_frame("s12_fA", 101, 102, 103, 104);
    check("s12_cnt", 32'(frame_cnt), 1);
    fft_done = 1'b1;
    step();
    fft_done = 1'b0;
    check("s12_cnt_rel", 32'(frame_cnt), 2);
    check("s12_ready_rel", 32'(in_ready), 1);
    check("s12_idle", 32'(busy), 0);
    step();                      // accepts 109, frame 2 issued
    check("s12_f2_start", 32'(start), 1);
    check_frame("s12_f2", 105, 106, 107, 108);
    in_data = 8'd110; step();
    in_data = 8'd111; step();
    in_data = 8'd112; step();
    in_valid = 1'b0;
    check("s12_both_full", 32'(in_ready), 0);
    fft_done = 1'b1;
    step();
    fft_done = 1'b0;
    check("s12_cnt3", 32'(frame_cnt), 3);
    step();
    check("s12_f3_start", 32'(start), 1);
    check_frame("s12_f3", 109, 110, 111, 112);
    step();
    fft_done = 1'b1;
    step();
    fft_done = 1'b0;
    check("s12_cnt4", 32'(frame_cnt), 4);

    // reset in the middle of a partial frame
    in_valid = 1'b1;
    in_data = 8'd55; step();
    in_data = 8'd66; step();
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_rst_ready", 32'(in_ready), 1);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_start", 32'(start), 0);
    check("mid_rst_cnt", 32'(frame_cnt), 0);
    step();
    reset = 1'b0;
    step();
    check("post_rst_nostart", 32'(start), 0);
    in_valid = 1'b1;
    in_data = 8'd1; step();
    in_data = 8'd2; step();
    in_data = 8'd3; step();
    in_data = 8'd4; step();
    in_valid = 1'b0;
    step();
    check("post_rst_start", 32'(start), 1);
    check_frame("post_rst", 1, 2, 3, 4);
    step();
    fft_done = 1'b1;
    step();
    fft_done = 1'b0;
    check("post_rst_cnt", 32'(frame_cnt), 1);

    // 256 frames, fft_done three cycles after each start
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    for (int f = 1; f <= 256; f++) begin
      in_valid = 1'b1;
      for (int s = 0; s < 4; s++) begin
        in_data = 8'(f + s);
        step();
      end
      in_valid = 1'b0;
      n = 0;
      while (!start && n < 8) begin
        step();
        n++;
      end
      check("wrap_start_seen", 32'(start), 1);
      step();
      step();
      fft_done = 1'b1;
      step();
      fft_done = 1'b0;
      if (f == 1)   check("wrap_cnt1", 32'(frame_cnt), 1);
      if (f == 255) check("wrap_cnt255", 32'(frame_cnt), 255);
      if (f == 256) check("wrap_cnt0", 32'(frame_cnt), 0);
    end

    // random in_valid, 1-cycle fft_done responses, order preserved
    frames_seen = 0;
    resp = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      fft_done = (resp == 1);
      if (resp != 0) resp--;
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      if (in_valid && in_ready) exp_q.push_back(in_data);
      step();
      if (start) begin
        check("rnd_depth", 32'(exp_q.size() >= 4), 1);
        if (exp_q.size() >= 4) begin
          check("rnd_x0", 32'(x0), 32'(exp_q.pop_front()));
          check("rnd_x1", 32'(x1), 32'(exp_q.pop_front()));
          check("rnd_x2", 32'(x2), 32'(exp_q.pop_front()));
          check("rnd_x3", 32'(x3), 32'(exp_q.pop_front()));
        end
        frames_seen++;
        resp = 2;
      end
    end
    fft_done = 1'b0;
    in_valid = 1'b0;
    check("rnd_frames_min", 32'(frames_seen >= 10), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
